// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: fetch handshake, memory status and datapath control strobes of the control unit
interface multicycle_control_unit_if;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic        memReady;
  logic        zero;
  logic [1:0]  seuSignal;
  logic        aluSrc;
  logic [3:0]  aluOp;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic        pcWrite;
  logic        pcSrc;
  logic        illegal;
  logic        busy;
  logic [15:0] retired;
  modport master (
    output instrValid, instruction, memReady, zero,
    input  instrReady, seuSignal, aluSrc, aluOp, regWrite, memRead, memWrite,
           memToReg, pcWrite, pcSrc, illegal, busy, retired
  );
  modport slave (
    input  instrValid, instruction, memReady, zero,
    output instrReady, seuSignal, aluSrc, aluOp, regWrite, memRead, memWrite,
           memToReg, pcWrite, pcSrc, illegal, busy, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: LEGv8-subset multicycle controller (IDLE/DECODE/EXEC/MEM/WB) with retirement counter
module multicycle_control_unit (
  input logic                   clk,
  input logic                   rst,
  multicycle_control_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  state_t      state, next;
  logic [10:0] ir;
  logic [15:0] retired_q;
  logic        is_r, is_i, is_ld, is_st, is_d, is_b, is_cbz, is_ill, retire, act;
  logic [1:0]  seu;
  logic [3:0]  op;
  // Only the opcode field steers control, so IR holds instruction[31:21]
  assign is_r   = ir inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
  assign is_ld  = ir == 11'b11111000010;
  assign is_st  = ir == 11'b11111000000;
  assign is_d   = is_ld | is_st;
  assign is_i   = !is_r && !is_d && (ir[10:1] inside {10'b1001000100, 10'b1101000100});
  assign is_cbz = !is_r && !is_d && !is_i && ir[10:3] == 8'b10110100;
  assign is_b   = !is_r && !is_d && !is_i && !is_cbz && ir[10:5] == 6'b000101;
  assign is_ill = !(is_r | is_i | is_d | is_cbz | is_b);
  assign seu    = is_b ? 2'b01 : is_cbz ? 2'b10 : is_d ? 2'b11 : 2'b00;
  assign op     = (ir == 11'b11001011000 || (is_i && ir[9])) ? 4'b0110 :
                  ir == 11'b10001010000 ? 4'b0000 :
                  ir == 11'b10101010000 ? 4'b0001 :
                  is_cbz ? 4'b0111 :
                  (is_r | is_i | is_d) ? 4'b0010 : 4'b0000;
  assign act    = rst && state != IDLE;
  always_ff @(posedge clk) begin
    state     <= !rst ? IDLE : next;
    ir        <= !rst ? 11'd0 : (state == IDLE && bus.instrValid) ? bus.instruction[31:21] : ir;
    retired_q <= !rst ? 16'd0 : retired_q + {15'd0, retire};
  end
  always_comb begin
    next   = state;
    retire = 1'b0;
    case (state)
      IDLE:    next = bus.instrValid ? DECODE : IDLE;
      DECODE:  next = is_ill ? IDLE : EXEC;
      EXEC: begin
        next   = (is_r | is_i) ? WB : is_d ? MEM : IDLE;
        retire = is_b | is_cbz;
      end
      MEM: begin
        next   = !bus.memReady ? MEM : is_ld ? WB : IDLE;
        retire = bus.memReady && is_st;
      end
      WB: begin
        next   = IDLE;
        retire = 1'b1;
      end
      default: next = IDLE;
    endcase
    // Outputs are gated by rst so everything reads 0 while reset is held
    bus.instrReady = rst && state == IDLE;
    bus.busy       = act;
    bus.illegal    = rst && state == DECODE && is_ill;
    bus.seuSignal  = act ? seu : 2'b00;
    bus.aluOp      = act ? op : 4'b0000;
    bus.aluSrc     = rst && (state inside {EXEC, MEM, WB}) && (is_i | is_d);
    bus.memRead    = rst && state == MEM && is_ld;
    bus.memWrite   = rst && state == MEM && is_st;
    bus.regWrite   = rst && state == WB;
    bus.memToReg   = rst && state == WB && is_ld;
    bus.pcWrite    = rst && state == EXEC && (is_b | is_cbz);
    bus.pcSrc      = rst && state == EXEC && (is_b | (is_cbz & bus.zero));
    bus.retired    = rst ? retired_q : 16'd0;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table of instructions expanded into per-cycle expected words on a scoreboard queue
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  multicycle_control_unit_if bus();
  multicycle_control_unit dut (.clk(clk), .rst(rst), .bus(bus));
  typedef enum {K_R, K_I, K_LD, K_ST, K_B, K_CB, K_ILL} kind_t;
  typedef struct {
    string       name;
    logic [31:0] instr;
    kind_t       kind;
    int          waits;
    logic        z;
    logic [1:0]  seu;
    logic [3:0]  op;
  } vec_t;
  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt = 16'd0;
  logic [31:0] exp_q[$];
  vec_t        tbl[16];
  function automatic logic [31:0] pack(input logic rdy, input logic bsy, input logic ill,
      input logic [1:0] seu, input logic asrc, input logic [3:0] op, input logic rw,
      input logic mr, input logic mw, input logic m2r, input logic pw, input logic ps,
      input logic [15:0] ret);
    return {rdy, bsy, ill, seu, asrc, op, rw, mr, mw, m2r, pw, ps, ret};
  endfunction
  function automatic logic [31:0] idle_word(input logic [15:0] ret);
    return pack(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ret);
  endfunction
  task automatic step(input string name);
    logic [31:0] got, want;
    #1;
    got = pack(bus.instrReady, bus.busy, bus.illegal, bus.seuSignal, bus.aluSrc, bus.aluOp,
               bus.regWrite, bus.memRead, bus.memWrite, bus.memToReg, bus.pcWrite, bus.pcSrc,
               bus.retired);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got %h want %h", name, got, want);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t v);
    logic a, pw, ps, ld, st;
    int   n;
    a  = v.kind inside {K_I, K_LD, K_ST};
    pw = v.kind inside {K_B, K_CB};
    ps = v.kind == K_B || (v.kind == K_CB && v.z);
    ld = v.kind == K_LD;
    st = v.kind == K_ST;
    exp_q.push_back(idle_word(cnt));
    if (v.kind == K_ILL)
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt));
    else begin
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, v.seu, 1'b0, v.op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, v.seu, a, v.op, 1'b0, 1'b0, 1'b0, 1'b0, pw, ps, cnt));
      if (ld || st)
        for (int i = 0; i <= v.waits; i++)
          exp_q.push_back(pack(1'b0, 1'b1, 1'b0, v.seu, 1'b1, v.op, 1'b0, ld, st, 1'b0, 1'b0, 1'b0, cnt));
      if (v.kind inside {K_R, K_I, K_LD})
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, v.seu, a, v.op, 1'b1, 1'b0, 1'b0, ld, 1'b0, 1'b0, cnt));
    end
    n = exp_q.size();
    bus.instruction = v.instr;
    bus.zero        = v.z;
    // instrValid stays high so a premature accept on the retire cycle would show up
    for (int i = 0; i < n; i++) begin
      bus.instrValid = 1'b1;
      bus.memReady   = (i < 3) || (i == 3 + v.waits);
      step(v.name);
    end
    if (v.kind != K_ILL) cnt++;
  endtask
  initial begin
    tbl[0]  = '{"add",   32'h8B020020, K_R,   0, 1'b0, 2'b00, 4'b0010};
    tbl[1]  = '{"sub",   32'hCB000000, K_R,   0, 1'b0, 2'b00, 4'b0110};
    tbl[2]  = '{"and",   32'h8A000000, K_R,   0, 1'b0, 2'b00, 4'b0000};
    tbl[3]  = '{"orr",   32'hAA000000, K_R,   0, 1'b0, 2'b00, 4'b0001};
    tbl[4]  = '{"addi",  32'h91000421, K_I,   0, 1'b0, 2'b00, 4'b0010};
    tbl[5]  = '{"subi",  32'hD1000000, K_I,   0, 1'b0, 2'b00, 4'b0110};
    tbl[6]  = '{"addi2", 32'h91200000, K_I,   0, 1'b1, 2'b00, 4'b0010};
    tbl[7]  = '{"ldur3", 32'hF8400000, K_LD,  3, 1'b0, 2'b11, 4'b0010};
    tbl[8]  = '{"ldur0", 32'hF8400000, K_LD,  0, 1'b0, 2'b11, 4'b0010};
    tbl[9]  = '{"stur2", 32'hF8000000, K_ST,  2, 1'b0, 2'b11, 4'b0010};
    tbl[10] = '{"cbz_t", 32'hB4000000, K_CB,  0, 1'b1, 2'b10, 4'b0111};
    tbl[11] = '{"cbz_f", 32'hB4000000, K_CB,  0, 1'b0, 2'b10, 4'b0111};
    tbl[12] = '{"b",     32'h17FFFFFF, K_B,   0, 1'b0, 2'b01, 4'b0000};
    tbl[13] = '{"ill0",  32'h00000000, K_ILL, 0, 1'b0, 2'b00, 4'b0000};
    tbl[14] = '{"ill1",  32'h8B200000, K_ILL, 0, 1'b1, 2'b00, 4'b0000};
    tbl[15] = '{"stur0", 32'hF8000000, K_ST,  0, 1'b0, 2'b11, 4'b0010};
    bus.instrValid  = 1'b1;
    bus.instruction = 32'h8B020020;
    bus.memReady    = 1'b1;
    bus.zero        = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd0);
    step("reset0");
    exp_q.push_back(32'd0);
    step("reset1");
    rst = 1'b1;
    bus.instrValid = 1'b0;
    exp_q.push_back(idle_word(16'd0));
    step("reset_exit");
    foreach (tbl[k]) run(tbl[k]);
    bus.instrValid = 1'b0;
    exp_q.push_back(idle_word(cnt));
    step("idle_no_valid");
    // Reset in the middle of a STUR memory wait
    bus.instruction = 32'hF8000000;
    exp_q.push_back(idle_word(cnt));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cnt));
    for (int i = 0; i < 4; i++) begin
      bus.instrValid = 1'b1;
      bus.memReady   = i < 3;
      step("stur_wait");
    end
    rst = 1'b0;
    bus.memReady = 1'b0;
    exp_q.push_back(32'd0);
    step("rst_in_mem");
    exp_q.push_back(32'd0);
    step("rst_held");
    rst = 1'b1;
    bus.instrValid = 1'b0;
    cnt = 16'd0;
    exp_q.push_back(idle_word(16'd0));
    step("rst_release");
    exp_q.push_back(idle_word(16'd0));
    step("rst_memready_ignored");
    // Counter wrap on a B retirement
    force dut.retired_q = 16'hFFFF;
    release dut.retired_q;
    cnt = 16'hFFFF;
    run(tbl[12]);
    bus.instrValid = 1'b0;
    exp_q.push_back(idle_word(cnt));
    step("wrap");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset; all state SHALL change on the rising edge of clk only.
REQ-002 Port list (name, direction, width, meaning):
- clk in 1: clock.
- rst in 1: synchronous reset, active-low.
- instrValid in 1: fetch offers an instruction.
- instrReady out 1: unit accepts an instruction.
- instruction in 32: instruction word.
- memReady in 1: data memory access complete.
- zero in 1: ALU zero flag.
- seuSignal out 2: sign-extension mode (00 ALU immediate, 01 branch address, 10 conditional-branch address, 11 data-transfer address).
- aluSrc out 1: 1 selects the extended immediate.
- aluOp out 4: ALU operation.
- regWrite, memRead, memWrite, memToReg, pcWrite, pcSrc out 1 each: datapath strobes.
- illegal out 1: one-cycle pulse on an undecodable opcode.
- busy out 1: high when not in IDLE.
- retired out 16: count of completed legal instructions.

Function
REQ-003 States SHALL be IDLE, DECODE, EXEC, MEM and WB.
REQ-004 instrReady SHALL be 1 only in IDLE; a handshake (instrValid && instrReady) SHALL latch instruction into an internal IR and move to DECODE; otherwise the unit SHALL stay in IDLE.
REQ-005 DECODE SHALL classify IR[31:21]:
- R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- I-type: IR[31:22] ADDI 1001000100, SUBI 1101000100.
- D-type: LDUR 11111000010, STUR 11111000000.
- B: IR[31:26] 000101.
- CBZ: IR[31:24] 10110100.
- Anything else is illegal.
REQ-006 Match priority SHALL be R/D (11 bits) > I (10 bits) > CBZ (8 bits) > B (6 bits).
REQ-007 An illegal opcode SHALL assert illegal for exactly the DECODE cycle, return to IDLE on the next edge, and leave retired unchanged.
REQ-008 seuSignal SHALL be driven from the latched class in DECODE through WB, and SHALL be 00 in IDLE:
- 00 for I-type and R-type.
- 01 for B.
- 10 for CBZ.
- 11 for LDUR/STUR.
REQ-009 aluOp SHALL be:
- 0010 for ADD/ADDI/LDUR/STUR.
- 0110 for SUB/SUBI.
- 0000 for AND.
- 0001 for ORR.
- 0111 (pass B) for CBZ.
- 0000 for B and in IDLE.
REQ-010 aluSrc SHALL be 1 in EXEC, MEM and WB for I-type and D-type, and 0 otherwise.
REQ-011 State sequences and latencies, counted from the handshake edge:
- R/I: DECODE, EXEC, WB, IDLE (4 cycles).
- LDUR: DECODE, EXEC, MEM (wait), WB, IDLE.
- STUR: DECODE, EXEC, MEM (wait), IDLE.
- B and CBZ: DECODE, EXEC, IDLE.
REQ-012 In MEM, memRead (LDUR) or memWrite (STUR) SHALL be held high every cycle until memReady=1. The unit SHALL leave MEM on the edge where memReady=1 and SHALL remain in MEM indefinitely otherwise. memReady SHALL be ignored in all other states.
REQ-013 In WB, regWrite SHALL be 1 for one cycle; memToReg SHALL be 1 only for LDUR.
REQ-014 In EXEC for B, pcWrite=1 and pcSrc=1. In EXEC for CBZ, pcWrite=1 and pcSrc=zero sampled that cycle. pcWrite/pcSrc SHALL be 0 in all other states.
REQ-015 retired SHALL increment by 1 on the final-state exit edge of each legal instruction (WB→IDLE, MEM→IDLE for STUR, EXEC→IDLE for B/CBZ). It SHALL wrap 0xFFFF→0x0000.
REQ-016 All strobes not listed for a state SHALL be 0. busy SHALL equal (state != IDLE).
REQ-017 A new instruction SHALL NOT be accepted in the cycle the previous one retires; the earliest next handshake is the following IDLE cycle.

Reset
REQ-018 When rst=0 at a clock edge, from any state including MEM mid-wait, the unit SHALL go to IDLE and clear IR and retired to 0. The pending memory access SHALL be abandoned.
REQ-019 While rst=0, all outputs SHALL be 0, including instrReady. instrReady SHALL rise in the first cycle after rst returns to 1.

Verification
REQ-020 ADDI (0x91000421) handshake → DECODE/EXEC/WB; seuSignal=00, aluSrc=1, aluOp=0010; regWrite=1 in WB only; retired 0→1 after 4 cycles.
REQ-021 LDUR with memReady low 3 cycles, then high → memRead=1 for 4 MEM cycles; WB has regWrite=1, memToReg=1; seuSignal=11 throughout.
REQ-022 CBZ with zero=1, then a second CBZ with zero=0 → EXEC pcWrite=1 both times; pcSrc=1 then 0; seuSignal=10; each takes 3 cycles.
REQ-023 Opcode 0x00000000 → illegal=1 for one cycle, back to IDLE, retired unchanged, no strobes asserted.
REQ-024 rst=0 during the MEM wait of STUR → next cycle IDLE, memWrite=0, retired=0, instrReady=0 until rst=1.
REQ-025 Preload 0xFFFF retirements (or force) then retire B → retired=0x0000; pcSrc=1, seuSignal=01.
